// File: rtl/halfaddr_rb_pkg.sv
// Shared parameters and FSM state type for the half-adder result
// readback block.
package halfaddr_rb_pkg;

    localparam int ADDR_W = 4;
    localparam int DEPTH  = 16;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        SCAN,
        DONE
    } state_t;

endpackage

// File: rtl/halfaddr_rb_mem.sv
// Result storage: per-slot {valid, carry, sum}, one write port,
// one asynchronous read port, synchronous clear of all valid bits.
module halfaddr_rb_mem #(
    parameter int ADDR_W = halfaddr_rb_pkg::ADDR_W,
    parameter int DEPTH  = halfaddr_rb_pkg::DEPTH
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic              wr_sum,
    input  logic              wr_carry,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_valid,
    output logic              rd_sum,
    output logic              rd_carry
);

    logic [DEPTH-1:0] valid_q;
    logic [DEPTH-1:0] sum_q;
    logic [DEPTH-1:0] carry_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            sum_q   <= '0;
            carry_q <= '0;
        end else begin
            if (wr_en) begin
                sum_q[wr_addr]   <= wr_sum;
                carry_q[wr_addr] <= wr_carry;
            end
            // clear beats a same-cycle write: the slot stays invalid
            if (clear)
                valid_q <= '0;
            else if (wr_en)
                valid_q[wr_addr] <= 1'b1;
        end
    end

    assign rd_valid = valid_q[rd_addr];
    assign rd_sum   = sum_q[rd_addr];
    assign rd_carry = carry_q[rd_addr];

endmodule

// File: rtl/halfaddr_readback.sv
// Half-adder result table with single-entry readback and a
// full-table scan that counts valid and carry-set slots.
module halfaddr_readback
    import halfaddr_rb_pkg::*;
#(
    parameter int ADDR_W = halfaddr_rb_pkg::ADDR_W,
    parameter int DEPTH  = halfaddr_rb_pkg::DEPTH
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic              wr_sum,
    input  logic              wr_carry,
    input  logic              clear,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_ack,
    output logic              rd_sum,
    output logic              rd_carry,
    output logic              rd_hit,
    input  logic              scan_start,
    output logic              scan_done,
    output logic [ADDR_W:0]   valid_cnt,
    output logic [ADDR_W:0]   carry_cnt,
    output logic              busy
);

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    state_t            state_q;
    state_t            state_d;
    logic              rd_take;
    logic              scan_take;
    logic [ADDR_W-1:0] ptr_q;
    logic [ADDR_W-1:0] mem_addr;
    logic              m_valid;
    logic              m_sum;
    logic              m_carry;

    // single read port shared between readback and scan
    assign mem_addr = (state_q == SCAN) ? ptr_q : rd_addr;

    halfaddr_rb_mem #(
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_mem (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (clear),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_sum   (wr_sum),
        .wr_carry (wr_carry),
        .rd_addr  (mem_addr),
        .rd_valid (m_valid),
        .rd_sum   (m_sum),
        .rd_carry (m_carry)
    );

    always_comb begin
        state_d   = state_q;
        rd_take   = 1'b0;
        scan_take = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (rd_req) begin
                    state_d = READ;
                    rd_take = 1'b1;
                end else if (scan_start) begin
                    state_d   = SCAN;
                    scan_take = 1'b1;
                end
            end
            READ: state_d = IDLE;
            SCAN: if (ptr_q == LAST) state_d = DONE;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            valid_cnt <= '0;
            carry_cnt <= '0;
            rd_hit    <= 1'b0;
            rd_sum    <= 1'b0;
            rd_carry  <= 1'b0;
        end else begin
            state_q <= state_d;
            // captured from pre-write contents at acceptance
            if (rd_take) begin
                rd_hit   <= m_valid;
                rd_sum   <= m_valid & m_sum;
                rd_carry <= m_valid & m_carry;
            end
            if (scan_take) begin
                ptr_q     <= '0;
                valid_cnt <= '0;
                carry_cnt <= '0;
            end else if (state_q == SCAN) begin
                ptr_q <= ptr_q + ADDR_W'(1);
                if (m_valid)
                    valid_cnt <= valid_cnt + (ADDR_W+1)'(1);
                if (m_valid && m_carry)
                    carry_cnt <= carry_cnt + (ADDR_W+1)'(1);
            end
        end
    end

    assign rd_ack    = (state_q == READ);
    assign scan_done = (state_q == DONE);
    assign busy      = (state_q == READ) || (state_q == SCAN);

endmodule

// File: tb/tb_halfaddr_readback.sv
// Directed bench for halfaddr_readback: readback, scan timing,
// arbitration, clear and reset behaviour.
module tb_halfaddr_readback;

    logic       clk;
    logic       rst_n;
    logic       wr_en;
    logic [3:0] wr_addr;
    logic       wr_sum;
    logic       wr_carry;
    logic       clear;
    logic       rd_req;
    logic [3:0] rd_addr;
    logic       rd_ack;
    logic       rd_sum;
    logic       rd_carry;
    logic       rd_hit;
    logic       scan_start;
    logic       scan_done;
    logic [4:0] valid_cnt;
    logic [4:0] carry_cnt;
    logic       busy;

    int total;
    int passes;

    halfaddr_readback dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_sum     (wr_sum),
        .wr_carry   (wr_carry),
        .clear      (clear),
        .rd_req     (rd_req),
        .rd_addr    (rd_addr),
        .rd_ack     (rd_ack),
        .rd_sum     (rd_sum),
        .rd_carry   (rd_carry),
        .rd_hit     (rd_hit),
        .scan_start (scan_start),
        .scan_done  (scan_done),
        .valid_cnt  (valid_cnt),
        .carry_cnt  (carry_cnt),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic wr(input logic [3:0] a, input logic s, input logic c);
        wr_en    = 1'b1;
        wr_addr  = a;
        wr_sum   = s;
        wr_carry = c;
        step();
        wr_en = 1'b0;
    endtask

    task automatic rd(input logic [3:0] a);
        rd_req  = 1'b1;
        rd_addr = a;
        step();
        rd_req = 1'b0;
    endtask

    // steps until scan_done or budget; returns cycles taken
    task automatic wait_done(output int n, output int nbusy);
        n     = 1;
        nbusy = 0;
        while (!scan_done && n < 40) begin
            if (busy) nbusy++;
            step();
            n++;
        end
    endtask

    initial begin
        int n;
        int nb;
        int acks;
        int dones;
        total      = 0;
        passes     = 0;
        rst_n      = 1'b0;
        wr_en      = 1'b0;
        wr_addr    = '0;
        wr_sum     = 1'b0;
        wr_carry   = 1'b0;
        clear      = 1'b0;
        rd_req     = 1'b0;
        rd_addr    = '0;
        scan_start = 1'b0;
        #12;
        chk("rst_ack", rd_ack, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", scan_done, 0);
        chk("rst_vcnt", valid_cnt, 0);
        chk("rst_hit", rd_hit, 0);
        rst_n = 1'b1;
        step();

        // empty slot read
        rd(4'd5);
        chk("r5_ack", rd_ack, 1);
        chk("r5_hit", rd_hit, 0);
        chk("r5_sum", rd_sum, 0);
        chk("r5_carry", rd_carry, 0);
        chk("r5_busy", busy, 1);
        step();
        chk("r5_ack_low", rd_ack, 0);

        // same-cycle write and read sees old contents
        wr_en    = 1'b1;
        wr_addr  = 4'd2;
        wr_sum   = 1'b1;
        wr_carry = 1'b0;
        rd_req   = 1'b1;
        rd_addr  = 4'd2;
        step();
        wr_en  = 1'b0;
        rd_req = 1'b0;
        chk("rbw_ack", rd_ack, 1);
        chk("rbw_hit", rd_hit, 0);
        step();
        rd(4'd2);
        chk("rbw2_hit", rd_hit, 1);
        chk("rbw2_sum", rd_sum, 1);
        step();

        // half-adder truth table: 0+0,0+1,1+0,1+1
        wr(4'd0, 1'b0, 1'b0);
        wr(4'd1, 1'b1, 1'b0);
        wr(4'd2, 1'b1, 1'b0);
        wr(4'd3, 1'b0, 1'b1);
        rd(4'd3);
        chk("r3_hit", rd_hit, 1);
        chk("r3_sum", rd_sum, 0);
        chk("r3_carry", rd_carry, 1);
        step();
        chk("r3_hold_carry", rd_carry, 1);
        chk("r3_hold_hit", rd_hit, 1);
        rd(4'd1);
        chk("r1_sum", rd_sum, 1);
        chk("r1_carry", rd_carry, 0);
        step();

        // full scan
        scan_start = 1'b1;
        step();
        scan_start = 1'b0;
        wait_done(n, nb);
        chk("scan_latency", n, 17);
        chk("scan_busy_cycles", nb, 16);
        chk("scan_done", scan_done, 1);
        chk("scan_vcnt", valid_cnt, 4);
        chk("scan_ccnt", carry_cnt, 1);
        step();
        chk("scan_done_pulse", scan_done, 0);
        step();
        step();
        chk("scan_vcnt_hold", valid_cnt, 4);

        // rd_req wins over scan_start
        rd_req     = 1'b1;
        rd_addr    = 4'd3;
        scan_start = 1'b1;
        step();
        rd_req     = 1'b0;
        scan_start = 1'b0;
        chk("arb_ack", rd_ack, 1);
        acks  = 0;
        dones = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (rd_ack) acks++;
            if (scan_done || busy) dones++;
        end
        chk("arb_single_ack", acks, 0);
        chk("arb_no_scan", dones, 0);

        // rd_req during scan is dropped
        scan_start = 1'b1;
        step();
        scan_start = 1'b0;
        rd_req     = 1'b1;
        acks       = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (rd_ack) acks++;
        end
        rd_req = 1'b0;
        wait_done(n, nb);
        chk("scan_rd_ignored", acks, 0);
        chk("scan2_vcnt", valid_cnt, 4);
        step();
        step();

        // clear mid-scan: slot 10 visited after clear
        wr(4'd10, 1'b1, 1'b1);
        scan_start = 1'b1;
        step();
        scan_start = 1'b0;
        for (int i = 0; i < 5; i++) step();
        clear = 1'b1;
        step();
        clear = 1'b0;
        wait_done(n, nb);
        chk("clr_scan_done", scan_done, 1);
        chk("clr_scan_vcnt", valid_cnt, 4);
        chk("clr_scan_ccnt", carry_cnt, 1);
        step();
        step();

        // reset at scan address 7
        wr(4'd4, 1'b0, 1'b1);
        rd(4'd4);
        step();
        scan_start = 1'b1;
        step();
        scan_start = 1'b0;
        for (int i = 0; i < 7; i++) step();
        rst_n = 1'b0;
        #2;
        chk("rrst_busy", busy, 0);
        chk("rrst_vcnt", valid_cnt, 0);
        chk("rrst_ccnt", carry_cnt, 0);
        chk("rrst_hit", rd_hit, 0);
        #3;
        rst_n = 1'b1;
        dones = 0;
        for (int i = 0; i < 25; i++) begin
            step();
            if (scan_done) dones++;
        end
        chk("rrst_no_done", dones, 0);

        // clear beats same-cycle write
        wr(4'd0, 1'b1, 1'b1);
        clear    = 1'b1;
        wr(4'd1, 1'b1, 1'b1);
        clear    = 1'b0;
        scan_start = 1'b1;
        step();
        scan_start = 1'b0;
        wait_done(n, nb);
        chk("cw_done", scan_done, 1);
        chk("cw_vcnt", valid_cnt, 0);
        chk("cw_ccnt", carry_cnt, 0);
        step();

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule

// File: doc/halfaddr_readback.md
HALFADDR_READBACK -- requirements
Module: halfaddr_readback

Interface
REQ-001 Parameter: ADDR_W, 4, result address width.
REQ-002 Parameter: DEPTH, 16, number of result entries (2**ADDR_W).
REQ-003 Port: clk  in  1  single clock, all state on rising edge.
REQ-004 Port: rst_n  in  1  reset, asynchronous, active-low.
REQ-005 Port: wr_en  in  1  producer writes one half-adder result this cycle.
REQ-006 Port: wr_addr  in  ADDR_W  result slot written.
REQ-007 Port: wr_sum  in  1  sum bit to store.
REQ-008 Port: wr_carry  in  1  carry bit to store.
REQ-009 Port: clear  in  1  synchronous invalidate of all slots.
REQ-010 Port: rd_req  in  1  single-entry read request, sampled only in IDLE.
REQ-011 Port: rd_addr  in  ADDR_W  slot to read, sampled with rd_req.
REQ-012 Port: rd_ack  out  1  one-cycle pulse, read data valid.
REQ-013 Port: rd_sum  out  1  stored sum of requested slot.
REQ-014 Port: rd_carry  out  1  stored carry of requested slot.
REQ-015 Port: rd_hit  out  1  requested slot held a valid result.
REQ-016 Port: scan_start  in  1  start full-table scan, sampled only in IDLE.
REQ-017 Port: scan_done  out  1  one-cycle pulse, counts final.
REQ-018 Port: valid_cnt  out  ADDR_W+1  valid slots found by last scan.
REQ-019 Port: carry_cnt  out  ADDR_W+1  valid slots with carry=1 found by last scan.
REQ-020 Port: busy  out  1  high in READ and SCAN states.

Function
REQ-021 Storage SHALL hold DEPTH entries of {valid, carry, sum}; a write sets valid=1 and stores carry/sum in any FSM state.
REQ-022 clear SHALL zero all valid bits; clear and wr_en in the same cycle -> clear wins, slot stays invalid.
REQ-023 FSM states SHALL be IDLE, READ, SCAN, DONE.
REQ-024 IDLE: rd_req=1 -> READ; else scan_start=1 -> SCAN with scan pointer 0, counters zeroed; both high -> rd_req wins, scan_start dropped.
REQ-025 READ SHALL last one cycle: rd_ack=1, rd_sum/rd_carry/rd_hit from the slot as it was before any same-cycle write (read-before-write), then -> IDLE.
REQ-026 rd_hit=0 SHALL force rd_sum=0 and rd_carry=0.
REQ-027 SCAN SHALL visit one address per cycle from 0 to DEPTH-1, incrementing valid_cnt for valid slots and carry_cnt for valid slots with carry=1, using pre-write contents.
REQ-028 After visiting DEPTH-1 the FSM SHALL enter DONE for one cycle with scan_done=1, then -> IDLE; full scan = DEPTH+1 cycles after start accepted.
REQ-029 valid_cnt/carry_cnt SHALL hold their final value until the next accepted scan_start; max value DEPTH without overflow.
REQ-030 rd_req and scan_start while busy or in DONE SHALL be ignored, not queued.
REQ-031 clear during SCAN SHALL not abort the scan; later-visited slots count as invalid.
REQ-032 rd_sum/rd_carry/rd_hit SHALL hold last read value between reads.

Reset
REQ-033 rst_n low SHALL asynchronously force state IDLE, all valid bits 0, scan pointer 0, all outputs 0.
REQ-034 Reset mid-READ or mid-SCAN SHALL abort without rd_ack or scan_done pulse; counts read 0.

Structure
REQ-035 Package halfaddr_rb_pkg SHALL hold ADDR_W, DEPTH defaults and the FSM state typedef.
REQ-036 Storage SHALL be sub-module halfaddr_rb_mem (valid/carry/sum array, one write port, one async read port, clear).

Verification
REQ-037 After reset, read addr 5 -> next cycle rd_ack=1, rd_hit=0, rd_sum=0, rd_carry=0.
REQ-038 Write addr 0..3 with (a,b) truth table results {s,c}=00,10,10,01, read addr 3 -> rd_hit=1, rd_sum=0, rd_carry=1.
REQ-039 Same table then scan_start -> scan_done exactly 17 cycles later, valid_cnt=4, carry_cnt=1; busy high 16 cycles.
REQ-040 Write addr 2 and rd_req addr 2 same cycle on empty slot -> rd_hit=0; re-read -> rd_hit=1.
REQ-041 rd_req and scan_start together in IDLE -> single rd_ack, no scan; rd_req during SCAN -> no rd_ack.
REQ-042 rst_n low at scan address 7 -> no scan_done, counts 0, busy 0; clear with wr_en addr 1 -> later scan valid_cnt=0.
